// File: rtl/plab4_net_cong_queue_pkg.sv
// Shared network constants: route directions and the default free-count width.
// No logic; imported by the congestion queue and route compute.
// No backpressure: constants only.
package plab4_net_cong_queue_pkg;

    typedef enum logic [1:0] {
        ROUTE_PREV = 2'd0,
        ROUTE_NEXT = 2'd1,
        ROUTE_TERM = 2'd2
    } route_t;

    // Must agree with the route-compute free-count width.
    localparam int NUM_FREE_NBITS_DFLT = 2;

    function automatic int free_sat_max(input int nbits);
        return (1 << nbits) - 1;
    endfunction

endpackage

// File: rtl/plab4_net_cong_queue_ctrl.sv
// Queue control: pointers, occupancy, handshake flags and registered free count.
// Latency: flags come from registered state; num_free lags the handshake by one edge.
// Backpressure: enq_rdy drops only when full; a same-cycle dequeue does not reopen it.
module plab4_net_cong_queue_ctrl
    import plab4_net_cong_queue_pkg::*;
#(
    parameter  int p_num_entries    = 4,
    parameter  int p_num_free_nbits = NUM_FREE_NBITS_DFLT,
    localparam int c_addr_nbits     = $clog2(p_num_entries),
    localparam int c_cnt_nbits      = $clog2(p_num_entries + 1)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enq_val,
    output logic                        enq_rdy,
    input  logic                        deq_rdy,
    output logic                        deq_val,
    output logic                        enq_fire,
    output logic [c_addr_nbits-1:0]     wr_ptr,
    output logic [c_addr_nbits-1:0]     rd_ptr,
    output logic [p_num_free_nbits-1:0] num_free
);

    localparam int c_wide_nbits = c_cnt_nbits + 1;
    localparam int c_sat        = free_sat_max(p_num_free_nbits);
    localparam int c_rst_free   = (p_num_entries < c_sat) ? p_num_entries : c_sat;

    logic [c_addr_nbits-1:0]     wr_ptr_q, wr_ptr_d;
    logic [c_addr_nbits-1:0]     rd_ptr_q, rd_ptr_d;
    logic [c_cnt_nbits-1:0]      count_q, count_d;
    logic [p_num_free_nbits-1:0] num_free_q, num_free_d;
    logic [c_wide_nbits-1:0]     free_wide;
    logic                        deq_fire;

    always_comb begin
        enq_rdy   = (count_q != c_cnt_nbits'(p_num_entries));
        deq_val   = (count_q != '0);
        enq_fire  = enq_val && enq_rdy;
        deq_fire  = deq_rdy && deq_val;

        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (enq_fire) wr_ptr_d = wr_ptr_q + c_addr_nbits'(1);
        if (deq_fire) rd_ptr_d = rd_ptr_q + c_addr_nbits'(1);
        if (enq_fire && !deq_fire)      count_d = count_q + c_cnt_nbits'(1);
        else if (deq_fire && !enq_fire) count_d = count_q - c_cnt_nbits'(1);

        // One extra bit so the subtraction can never wrap before saturating.
        free_wide = c_wide_nbits'(p_num_entries) - {1'b0, count_d};
        if (int'(free_wide) > c_sat) num_free_d = p_num_free_nbits'(c_sat);
        else                         num_free_d = p_num_free_nbits'(free_wide);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            num_free_q <= p_num_free_nbits'(c_rst_free);
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            num_free_q <= num_free_d;
        end
    end

    assign wr_ptr   = wr_ptr_q;
    assign rd_ptr   = rd_ptr_q;
    assign num_free = num_free_q;

endmodule

// File: rtl/plab4_net_cong_queue.sv
// Router input-channel FIFO carrying message + domain bit; reports saturated free count.
// Latency: 1 cycle enqueue-to-head, no bypass; full rate when neither empty nor full.
// Backpressure: val/rdy on both sides; enq_rdy low only when all entries are occupied.
module plab4_net_cong_queue
    import plab4_net_cong_queue_pkg::*;
#(
    parameter  int p_msg_nbits      = 32,
    parameter  int p_num_entries    = 4,
    parameter  int p_num_free_nbits = NUM_FREE_NBITS_DFLT,
    localparam int c_addr_nbits     = $clog2(p_num_entries)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enq_val,
    output logic                        enq_rdy,
    input  logic [p_msg_nbits-1:0]      enq_msg,
    input  logic                        enq_domain,
    output logic                        deq_val,
    input  logic                        deq_rdy,
    output logic [p_msg_nbits-1:0]      deq_msg,
    output logic                        deq_domain,
    output logic [p_num_free_nbits-1:0] num_free
);

    logic                    enq_fire;
    logic [c_addr_nbits-1:0] wr_ptr;
    logic [c_addr_nbits-1:0] rd_ptr;

    // Domain bit sits in the MSB of each entry so it travels with its message.
    logic [p_msg_nbits:0] mem_q [p_num_entries];
    logic [p_msg_nbits:0] mem_d [p_num_entries];

    plab4_net_cong_queue_ctrl #(
        .p_num_entries    (p_num_entries),
        .p_num_free_nbits (p_num_free_nbits)
    ) u_ctrl (
        .clk      (clk),
        .reset    (reset),
        .enq_val  (enq_val),
        .enq_rdy  (enq_rdy),
        .deq_rdy  (deq_rdy),
        .deq_val  (deq_val),
        .enq_fire (enq_fire),
        .wr_ptr   (wr_ptr),
        .rd_ptr   (rd_ptr),
        .num_free (num_free)
    );

    always_comb begin
        mem_d = mem_q;
        if (enq_fire) mem_d[wr_ptr] = {enq_domain, enq_msg};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < p_num_entries; i++) mem_q[i] <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign deq_msg    = mem_q[rd_ptr][p_msg_nbits-1:0];
    assign deq_domain = mem_q[rd_ptr][p_msg_nbits];

endmodule
